// File: rtl/ascon_pin_host.sv
// Byte-serial initiator for the tt_um_snn_ascon pin interface: streams key, nonce and
// plaintext onto ui_in/uio_in, pulses start, then collects ciphertext and tag bytes.
module ascon_pin_host #(
  parameter int unsigned INIT_WAIT  = 30,
  parameter int unsigned RD_TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [63:0]  pt,
  input  logic [3:0]   pt_len,
  output logic         ready,
  output logic         done,
  output logic         error,
  output logic [63:0]  ct,
  output logic [127:0] tag,
  output logic [7:0]   dut_ui,
  output logic [7:0]   dut_uio,
  input  logic [7:0]   dut_uo,
  input  logic [7:0]   dut_status
);

  localparam int unsigned WaitMax = (INIT_WAIT > RD_TIMEOUT) ? INIT_WAIT : RD_TIMEOUT;
  localparam int unsigned WaitW   = $clog2(WaitMax + 2);
  localparam logic [WaitW-1:0] InitLast = WaitW'(INIT_WAIT - 1);
  localparam logic [WaitW-1:0] RdLast   = WaitW'(RD_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StKey, StGapK, StNonce, StGapN, StGo,
    StInit, StData, StRdWait, StRdAck, StRdGap, StFin
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         byte_q, byte_d;
  logic [4:0]         rd_q, rd_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [127:0]       key_q, key_d, nonce_q, nonce_d;
  logic [63:0]        pt_q, pt_d;
  logic [3:0]         len_q, len_d;
  logic [63:0]        ct_q, ct_d;
  logic [127:0]       tag_q, tag_d;
  logic [7:0]         ui_q, ui_d, uio_q, uio_d;
  logic               ready_q, ready_d, done_q, done_d, error_q, error_d;
  logic [4:0]         len_ext, tidx;
  logic               unused_status;

  assign len_ext       = {1'b0, len_q};
  assign tidx          = rd_q - len_ext;
  assign unused_status = ^{dut_status[7:2], dut_status[0]};

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    rd_d    = rd_q;
    wait_d  = wait_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    pt_d    = pt_q;
    len_d   = len_q;
    ct_d    = ct_q;
    tag_d   = tag_q;
    ui_d    = 8'h00;
    uio_d   = 8'h00;
    ready_d = (state_q == StIdle);
    done_d  = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ready_q && start) begin
          if (pt_len == 4'd0 || pt_len > 4'd8) begin
            error_d = 1'b1;
          end else begin
            key_d   = key;
            nonce_d = nonce;
            pt_d    = pt;
            len_d   = pt_len;
            ct_d    = '0;
            tag_d   = '0;
            byte_d  = '0;
            state_d = StKey;
          end
        end
      end
      StKey: begin
        ui_d  = key_q[127:120];
        uio_d = 8'h40;
        key_d = {key_q[119:0], 8'h00};
        if (byte_q == 5'd15) begin
          byte_d  = '0;
          state_d = StGapK;
        end else begin
          byte_d = byte_q + 5'd1;
        end
      end
      StGapK: state_d = StNonce;
      StNonce: begin
        ui_d    = nonce_q[127:120];
        uio_d   = 8'h80;
        nonce_d = {nonce_q[119:0], 8'h00};
        if (byte_q == 5'd15) begin
          byte_d  = '0;
          state_d = StGapN;
        end else begin
          byte_d = byte_q + 5'd1;
        end
      end
      StGapN: state_d = StGo;
      StGo: begin
        uio_d   = 8'h10;
        wait_d  = '0;
        state_d = (INIT_WAIT == 0) ? StData : StInit;
      end
      StInit: begin
        if (wait_q == InitLast) begin
          wait_d  = '0;
          state_d = StData;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StData: begin
        ui_d = pt_q[63:56];
        pt_d = {pt_q[55:0], 8'h00};
        if (byte_q == len_ext - 5'd1) begin
          uio_d   = 8'hE0;
          byte_d  = '0;
          rd_d    = '0;
          wait_d  = '0;
          state_d = StRdWait;
        end else begin
          uio_d  = 8'hC0;
          byte_d = byte_q + 5'd1;
        end
      end
      StRdWait: begin
        if (dut_status[1]) begin
          // First pt_len bytes are ciphertext, the remaining 16 are the tag
          if (rd_q < len_ext) begin
            for (int i = 0; i < 8; i++) begin
              if (rd_q == 5'(i)) ct_d[63-8*i -: 8] = dut_uo;
            end
          end else begin
            for (int i = 0; i < 16; i++) begin
              if (tidx == 5'(i)) tag_d[127-8*i -: 8] = dut_uo;
            end
          end
          wait_d  = '0;
          state_d = StRdAck;
        end else if (wait_q == RdLast) begin
          error_d = 1'b1;
          wait_d  = '0;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRdAck: begin
        uio_d   = 8'h04;
        state_d = StRdGap;
      end
      StRdGap: begin
        if (rd_q == len_ext + 5'd15) begin
          state_d = StFin;
        end else begin
          rd_d    = rd_q + 5'd1;
          state_d = StRdWait;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      byte_q  <= '0;
      rd_q    <= '0;
      wait_q  <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      pt_q    <= '0;
      len_q   <= '0;
      ct_q    <= '0;
      tag_q   <= '0;
      ui_q    <= '0;
      uio_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      rd_q    <= rd_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      pt_q    <= pt_d;
      len_q   <= len_d;
      ct_q    <= ct_d;
      tag_q   <= tag_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign error   = error_q;
  assign ct      = ct_q;
  assign tag     = tag_q;
  assign dut_ui  = ui_q;
  assign dut_uio = uio_q;

endmodule
